// File: rtl/free_list_if.sv
// Rename-stage port bundle between the map table (master) and the free list (slave).
// FREE_LIST_CHECKPOINT_EN adds the checkpoint/rollback controls.
interface free_list_if #(
    parameter int NUM_PHYS_REG = 64,
    parameter int NUM_GEN_REG  = 32
);
    localparam int FL_SIZE = NUM_PHYS_REG - NUM_GEN_REG;
    localparam int PW      = $clog2(NUM_PHYS_REG);
    localparam int CW      = $clog2(FL_SIZE + 1);

    logic          dispatch_en;
    logic          retire_en;
    logic [PW:0]   retire_reg;
    logic [PW:0]   free_reg;
    logic          free_valid;
    logic [CW-1:0] free_count;
`ifdef FREE_LIST_CHECKPOINT_EN
    logic          checkpoint_en;
    logic          rollback_en;

    modport master (
        output dispatch_en, retire_en, retire_reg, checkpoint_en, rollback_en,
        input  free_reg, free_valid, free_count
    );
    modport slave (
        input  dispatch_en, retire_en, retire_reg, checkpoint_en, rollback_en,
        output free_reg, free_valid, free_count
    );
`else
    modport master (
        output dispatch_en, retire_en, retire_reg,
        input  free_reg, free_valid, free_count
    );
    modport slave (
        input  dispatch_en, retire_en, retire_reg,
        output free_reg, free_valid, free_count
    );
`endif
endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags: pops at dispatch, pushes at retire.
// Defining FREE_LIST_CHECKPOINT_EN adds a one-deep head-pointer checkpoint for mispredict rollback.
module free_list #(
    parameter int NUM_PHYS_REG = 64,
    parameter int NUM_GEN_REG  = 32
) (
    input  logic         clock,
    input  logic         reset,
    free_list_if.slave   fl
);
    localparam int FL_SIZE = NUM_PHYS_REG - NUM_GEN_REG;
    localparam int PW      = $clog2(NUM_PHYS_REG);
    localparam int IW      = (FL_SIZE > 1) ? $clog2(FL_SIZE) : 1;
    localparam int CW      = $clog2(FL_SIZE + 1);

    typedef struct packed {
        logic          wrap;
        logic [IW-1:0] idx;
    } ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t n;
        n = p;
        if (p.idx == IW'(FL_SIZE - 1)) begin
            n.idx  = '0;
            n.wrap = ~p.wrap;
        end else begin
            n.idx = p.idx + 1'b1;
        end
        return n;
    endfunction

    logic [PW-1:0] r_mem [FL_SIZE];
    ptr_t          r_head;
    ptr_t          r_tail;
    ptr_t          w_head_nxt;
    ptr_t          w_tail_nxt;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_rollback;
    logic          w_unused_ready;

    assign w_empty        = (r_head == r_tail);
    assign w_full         = (r_head.idx == r_tail.idx) && (r_head.wrap != r_tail.wrap);
    assign w_unused_ready = fl.retire_reg[PW];

`ifdef FREE_LIST_CHECKPOINT_EN
    ptr_t r_ckpt;
    ptr_t w_ckpt_nxt;
    assign w_rollback = fl.rollback_en;
`else
    assign w_rollback = 1'b0;
`endif

    // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned (no latch).
    always_comb begin
        w_pop      = fl.dispatch_en && !w_empty;
        // A full list still accepts a push when the head slot is vacated in the same cycle.
        w_push     = fl.retire_en && (!w_full || (w_pop && !w_rollback));
        w_head_nxt = w_pop  ? ptr_inc(r_head) : r_head;
        w_tail_nxt = w_push ? ptr_inc(r_tail) : r_tail;
`ifdef FREE_LIST_CHECKPOINT_EN
        w_ckpt_nxt = r_ckpt;
        if (fl.rollback_en) begin
            w_head_nxt = r_ckpt;
        end else if (fl.checkpoint_en) begin
            w_ckpt_nxt = w_head_nxt;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head <= '{wrap: 1'b0, idx: '0};
            r_tail <= '{wrap: 1'b1, idx: '0};
        end else begin
            r_head <= w_head_nxt;
            r_tail <= w_tail_nxt;
        end
    end

`ifdef FREE_LIST_CHECKPOINT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ckpt <= '{wrap: 1'b0, idx: '0};
        end else begin
            r_ckpt <= w_ckpt_nxt;
        end
    end
`endif

    // NOTE: this storage is reset on purpose, since the initial free tags must be present out of reset; it therefore maps to flops, not RAM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FL_SIZE; i++) begin
                r_mem[i] <= PW'(NUM_GEN_REG + i);
            end
        end else if (w_push) begin
            r_mem[r_tail.idx] <= fl.retire_reg[PW-1:0];
        end
    end

    // Occupancy is tail - head modulo 2*FL_SIZE, which also holds when FL_SIZE is not a power of two.
    always_comb begin
        if (r_head.wrap == r_tail.wrap) begin
            fl.free_count = CW'(r_tail.idx) - CW'(r_head.idx);
        end else begin
            fl.free_count = CW'(FL_SIZE) - CW'(r_head.idx) + CW'(r_tail.idx);
        end
    end

    assign fl.free_reg   = {1'b0, r_mem[r_head.idx]};
    assign fl.free_valid = !w_empty;

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: a tag-queue reference model queues expected outputs, a monitor compares them.
module tb_free_list;
    localparam int NPR = 64;
    localparam int NGR = 32;
    localparam int FL  = NPR - NGR;
`ifdef FREE_LIST_CHECKPOINT_EN
    localparam bit CKPT = 1'b1;
`else
    localparam bit CKPT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    free_list_if #(.NUM_PHYS_REG(NPR), .NUM_GEN_REG(NGR)) fl_if ();

    free_list #(.NUM_PHYS_REG(NPR), .NUM_GEN_REG(NGR)) dut (
        .clock (clk),
        .reset (rst_n),
        .fl    (fl_if.slave)
    );

    typedef struct {
        string name;
        bit    chk_reg;
        int    tag;
        bit    valid;
        int    count;
    } exp_t;

    exp_t exp_q[$];
    int   model_q[$];
    int   since_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        since_q.delete();
        for (int i = 0; i < FL; i++) model_q.push_back(NGR + i);
    endtask

    // Free tags are a plain queue; tags popped since the checkpoint go back to the front on rollback.
    task automatic model_step(input bit d, input bit r, input int tag, input bit c, input bit rb);
        bit pop;
        bit push;
        pop  = d && (model_q.size() > 0);
        push = r && ((model_q.size() < FL) || (pop && !(CKPT && rb)));
        if (CKPT && rb) begin
            for (int i = since_q.size() - 1; i >= 0; i--) model_q.push_front(since_q[i]);
            since_q.delete();
        end else if (pop) begin
            int t;
            t = model_q.pop_front();
            if (CKPT) since_q.push_back(t);
        end
        if (push) model_q.push_back(tag % 64);
        if (CKPT && c) since_q.delete();
    endtask

    task automatic push_exp(input string name);
        exp_t e;
        e.name    = name;
        e.valid   = model_q.size() > 0;
        e.count   = model_q.size();
        e.chk_reg = model_q.size() > 0;
        e.tag     = (model_q.size() > 0) ? model_q[0] : 0;
        exp_q.push_back(e);
    endtask

    task automatic drive_idle();
        fl_if.dispatch_en = 1'b0;
        fl_if.retire_en   = 1'b0;
        fl_if.retire_reg  = '0;
`ifdef FREE_LIST_CHECKPOINT_EN
        fl_if.checkpoint_en = 1'b0;
        fl_if.rollback_en   = 1'b0;
`endif
    endtask

    task automatic cycle(input string name, input bit d, input bit r, input int tag, input bit c, input bit rb);
        fl_if.dispatch_en = d;
        fl_if.retire_en   = r;
        fl_if.retire_reg  = 7'(tag);
`ifdef FREE_LIST_CHECKPOINT_EN
        fl_if.checkpoint_en = c;
        fl_if.rollback_en   = rb;
`endif
        @(posedge clk);
        model_step(d, r, tag, c, rb);
        #1;
        push_exp(name);
        drive_idle();
    endtask

    // Reset is asserted between clock edges and checked before any edge arrives.
    task automatic apply_reset(input string name);
        drive_idle();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({name, "_reg"},   32'(fl_if.free_reg),   32'd32);
        check({name, "_valid"}, 32'(fl_if.free_valid), 32'd1);
        check({name, "_count"}, 32'(fl_if.free_count), 32'd32);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, "_valid"}, 32'(fl_if.free_valid), 32'(e.valid));
                check({e.name, "_count"}, 32'(fl_if.free_count), 32'(e.count));
                if (e.chk_reg) check({e.name, "_reg"}, 32'(fl_if.free_reg), 32'(e.tag));
            end
        end
    end

    initial begin : stimulus
        drive_idle();
        #1 rst_n = 1'b0;
        #2;
        check("reset_hold_reg",   32'(fl_if.free_reg),   32'd32);
        check("reset_hold_valid", 32'(fl_if.free_valid), 32'd1);
        check("reset_hold_count", 32'(fl_if.free_count), 32'd32);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;

        repeat (3) cycle("idle", 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) cycle("pop_all", 1, 0, 0, 0, 0);
        cycle("pop_empty", 1, 0, 0, 0, 0);
        cycle("push5_pop_on_empty", 1, 1, 5, 0, 0);
        cycle("push9", 0, 1, 9 + 64, 0, 0);
        cycle("push17", 0, 1, 17, 0, 0);
        repeat (3) cycle("pop_fifo", 1, 0, 0, 0, 0);

        apply_reset("reset_a");
        for (int i = 0; i < 40; i++) cycle("full_pushpop", 1, 1, int'($urandom_range(0, 127)), 0, 0);
        cycle("full_push_drop", 0, 1, 7, 0, 0);

`ifdef FREE_LIST_CHECKPOINT_EN
        apply_reset("reset_b");
        repeat (4) cycle("ck_pop_pre", 1, 0, 0, 0, 0);
        cycle("ck_save", 0, 0, 0, 1, 0);
        repeat (6) cycle("ck_pop_post", 1, 0, 0, 0, 0);
        cycle("ck_rollback", 1, 1, 3, 0, 1);
        @(negedge clk);
        #1;
        check("ck_rollback_reg_const",   32'(fl_if.free_reg),   32'd36);
        check("ck_rollback_count_const", 32'(fl_if.free_count), 32'd29);
        repeat (29) cycle("ck_drain", 1, 0, 0, 0, 0);
`endif

        apply_reset("reset_c");
        for (int i = 0; i < 400; i++) begin
            bit d, r, c, rb;
            int tag;
            if (i == 200) apply_reset("reset_mid");
            d   = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            r   = $urandom_range(0, 1) == 1;
            c   = CKPT && ($urandom_range(0, 7) == 0);
            rb  = CKPT && ($urandom_range(0, 15) == 0);
            if (CKPT && (model_q.size() + since_q.size() >= FL)) r = 1'b0;
            tag = int'($urandom_range(0, 127));
            cycle("random", d, r, tag, c, rb);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/free_list.md
# free_list

Circular FIFO of free physical register tags that supplies the `free_reg` destination tag to the map table at dispatch and takes back each superseded tag at retire. It sits directly upstream of the map table in the rename stage. Every physical register not in the reset architectural mapping starts out free. Dispatch pops one tag per cycle and retire pushes one tag per cycle. An optional checkpoint restores the head pointer on branch mispredict.

## Interface
- `NUM_PHYS_REG`, default 64: total physical registers. Must be a power of two.
- `NUM_GEN_REG`, default 32: architectural registers. `FL_SIZE = NUM_PHYS_REG - NUM_GEN_REG`, and `PW = $clog2(NUM_PHYS_REG)`.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 = reset.
- `dispatch_en`  in  1  pop request; consumes `free_reg` this cycle.
- `retire_en`  in  1  push request.
- `retire_reg`  in  PW+1  tag being freed; bit PW (ready) is ignored.
- `free_reg`  out  PW+1  head tag; bit PW is always 0 (not ready).
- `free_valid`  out  1  list is not empty.
- `free_count`  out  $clog2(FL_SIZE+1)  number of entries held.
- `checkpoint_en`  in  1  save the head pointer. Present only with `FREE_LIST_CHECKPOINT_EN`.
- `rollback_en`  in  1  restore the saved head pointer. Present only with `FREE_LIST_CHECKPOINT_EN`.

## Operation
- Storage is an array of `FL_SIZE` tags of width PW.
- `head` and `tail` are each `$clog2(FL_SIZE)` bits plus one wrap bit.
  - Empty: the two pointers are fully equal.
  - Full: the index bits are equal and the wrap bits differ.
- `free_count = tail - head`, computed modulo 2·FL_SIZE.
- Reset (asynchronous, while `reset`=0):
  - Entry i = `NUM_GEN_REG + i`.
  - `head` = 0 with wrap 0; `tail` = 0 with wrap 1, i.e. full.
  - Checkpoint register = 0.
  - Outputs during reset: `free_reg`=32, `free_valid`=1, `free_count`=32 (defaults).
- Pop: when `dispatch_en && free_valid`, `head` advances by 1. If `free_valid`=0 the pop is ignored and the state is unchanged.
- Push: when `retire_en` and the list is not full, `retire_reg[PW-1:0]` is written at `tail` and `tail` advances. A push while full is dropped and the state is unchanged.
- Pop and push in the same cycle:
  - Both are applied and the count is unchanged.
  - There is no bypass: a push into an empty list does not make `free_valid` true until the next cycle.
- Pointers wrap from index FL_SIZE-1 to 0 and toggle the wrap bit.

## Timing
- `free_reg`, `free_valid` and `free_count` are combinational from registered state only. No input affects them in the same cycle.
- Pop and push take effect at the next rising edge.
- Single-cycle throughput: one pop and one push per cycle, with no stalls beyond the empty and full conditions.
- Reset deassertion is synchronised by the integrating environment. The first active edge after release may pop entry 0.

## Configuration
- `FREE_LIST_CHECKPOINT_EN` defined:
  - The `checkpoint_en` and `rollback_en` ports exist, plus a one-deep checkpoint register holding a head-pointer copy.
  - `checkpoint_en`: the checkpoint register loads the post-pop head of this cycle, so a branch that dispatches in this cycle is included.
  - `rollback_en`: `head` is loaded from the checkpoint and any same-cycle pop is discarded. A same-cycle push is still applied.
  - `checkpoint_en` and `rollback_en` together: rollback wins, and the checkpoint register holds the restored head.
  - Tags popped after the checkpoint become free again. They are never overwritten, because their slots lie outside `[tail, checkpoint head)`.
  - A reset in the middle of an operation clears the checkpoint register to 0.
- Undefined: the ports and the register are absent, and the head only advances by pops.

## Test plan
- Reset, then no activity. Required: `free_reg`=32, `free_valid`=1, `free_count`=32.
- 32 consecutive pops. Required: `free_reg` steps 32..63; then `free_valid`=0 and `free_count`=0; a 33rd pop leaves all state unchanged.
- From empty, push tags 5, 9, 17, then pop three times. Required: 5, 9, 17 in order; `free_count` goes 3→0.
- Full list with simultaneous push and pop for 40 cycles. Required: `free_count` stays 32, both pointers wrap, pushed tags reappear in FIFO order; a push while full with no pop is dropped.
- Checkpoint build:
  - Stimulus: pop 4, checkpoint, pop 6, then rollback with a same-cycle pop and a push of tag 3.
  - Required: `free_reg`=36, `free_count`=29, and tag 3 is held at the tail.
- `reset` pulsed low asynchronously (not at a clock edge) mid-stream. Required: the outputs return to the reset values immediately, without waiting for a clock edge.
